// File: rtl/icache_refill_ctrl_if.sv
// Fetch-side, memory-side and fill-side signals of the I-cache refill controller.
// master = refill controller, slave = fetch stage / memory / cache data array.
interface icache_refill_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic               fetch_req;
  logic [31:0]        pc;
  logic               hit;
  logic               stall;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_ack;
  logic [31:0]        mem_rdata;
  logic               fill_we;
  logic [31:0]        fill_addr;
  logic [31:0]        fill_data;
  logic               fill_done;
  logic [31:0]        line_base;
  logic [COUNT_W-1:0] miss_count;

  modport master (
    input  fetch_req, pc, hit, mem_ack, mem_rdata,
    output stall, mem_req, mem_addr, fill_we, fill_addr, fill_data,
           fill_done, line_base, miss_count
  );

  modport slave (
    output fetch_req, pc, hit, mem_ack, mem_rdata,
    input  stall, mem_req, mem_addr, fill_we, fill_addr, fill_data,
           fill_done, line_base, miss_count
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill controller: stalls fetch on a miss, refills the line
// critical word first with in-line wrap, then pulses fill_done to validate it.
module icache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int COUNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  icache_refill_ctrl_if.master bus
);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e             state_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        line_base_q;
  logic [BW-1:0]      beat_q;
  logic [BW-1:0]      ack_cnt_q;
  logic [COUNT_W-1:0] miss_count_q;
  logic               fill_done_q;

  logic          miss_det;
  logic          beat_ack;
  logic          last_beat;
  logic [BW-1:0] beat_nxt;
  logic          unused_pc_lsb;

  assign miss_det  = (state_q == S_IDLE) & bus.fetch_req & ~bus.hit;
  // mem_req_q is only high in S_REQ, so it also masks acks outside a refill
  assign beat_ack  = mem_req_q & bus.mem_ack;
  assign last_beat = (ack_cnt_q == BW'(LINE_WORDS - 1));
  assign beat_nxt  = beat_q + 1'b1;
  assign unused_pc_lsb = ^bus.pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      line_base_q  <= '0;
      beat_q       <= '0;
      ack_cnt_q    <= '0;
      miss_count_q <= '0;
      fill_done_q  <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (miss_det) begin
            state_q     <= S_REQ;
            line_base_q <= {bus.pc[31:OFF], {OFF{1'b0}}};
            beat_q      <= bus.pc[OFF-1:2];
            ack_cnt_q   <= '0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= {bus.pc[31:2], 2'b00};
            if (miss_count_q != {COUNT_W{1'b1}})
              miss_count_q <= miss_count_q + 1'b1;
          end
        end
        S_REQ: begin
          if (beat_ack) begin
            if (last_beat) begin
              state_q     <= S_DONE;
              mem_req_q   <= 1'b0;
              fill_done_q <= 1'b1;
            end else begin
              beat_q     <= beat_nxt;
              ack_cnt_q  <= ack_cnt_q + 1'b1;
              mem_addr_q <= line_base_q + {{(30-BW){1'b0}}, beat_nxt, 2'b00};
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stall      = (state_q != S_IDLE) | miss_det;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fill_we    = beat_ack;
  assign bus.fill_addr  = mem_addr_q;
  assign bus.fill_data  = bus.mem_rdata;
  assign bus.fill_done  = fill_done_q;
  assign bus.line_base  = line_base_q;
  assign bus.miss_count = miss_count_q;
endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss/refill controller for `instr_mem_cache` in the MIPS fetch stage. On a fetch miss it stalls the pipeline and fetches the whole line from main memory over a req/ack handshake, critical word first with wrap-around. It writes each returned word into the cache data array, then marks the line valid. It also keeps a saturating miss counter for performance monitoring.

## Interface
Parameters:
- `LINE_WORDS`, 4: words per cache line; power of two, ≥2.
- `COUNT_W`, 16: width of the miss counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  fetch stage presents a valid `pc` this cycle.
- `pc`  in  32  fetch address; word-aligned, bits [1:0] ignored.
- `hit`  in  1  cache lookup result for `pc`, combinational from `instr_mem_cache`.
- `stall`  out  1  freezes PC/IF-ID while high.
- `mem_req`  out  1  memory read request, registered.
- `mem_addr`  out  32  word address of the current beat, registered.
- `mem_ack`  in  1  one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  returned word.
- `fill_we`  out  1  write strobe to the cache data array.
- `fill_addr`  out  32  address of the word written; equals `mem_addr` in the write cycle.
- `fill_data`  out  32  word to write; equals `mem_rdata`.
- `fill_done`  out  1  one-cycle pulse: write tag of `line_base`, set valid.
- `line_base`  out  32  line-aligned address of the line being refilled.
- `miss_count`  out  COUNT_W  number of misses serviced, saturating.

## Operation
- OFF = log2(LINE_WORDS)+2 byte-offset bits. On capture, `line_base` = {pc[31:OFF], OFF'b0} and start beat = pc[OFF-1:2].
- States:
  - IDLE: on `fetch_req && !hit`, latch `line_base` and beat = start beat, increment `miss_count`, go to REQ.
  - REQ: `mem_req`=1, `mem_addr` = `line_base` + 4·beat. On `mem_ack`, `fill_we`=1 in the same cycle.
    - If this is not the last beat: beat = (beat+1) mod LINE_WORDS, stay in REQ.
    - If this was the LINE_WORDS-th ack: go to DONE.
  - DONE: `fill_done`=1, `mem_req`=0, go to IDLE.
- Beat order wraps inside the line. Example: LINE_WORDS=4 with pc offset 0x8 gives order 0x8, 0xC, 0x0, 0x4.
- `stall` = (state≠IDLE) | (state==IDLE & `fetch_req` & !`hit`). This is combinational, so a miss stalls in its detection cycle.
- `hit` is ignored outside IDLE. A refill always completes once started; it is never aborted or restarted.
- `mem_ack` while `mem_req`=0 is ignored: no write, no beat advance.
- `miss_count` increments by 1 per IDLE→REQ transition and holds at 2^COUNT_W−1.
- Reset values: state IDLE, `mem_req` 0, `mem_addr` 0, `line_base` 0, `miss_count` 0, beat 0. Combinational outputs then follow: `fill_we` 0, `fill_done` 0, `stall` = `fetch_req` & !`hit`.
- Reset asserted mid-refill: at the next edge go to IDLE with `mem_req`=0. No `fill_done` is issued, so the line stays invalid and the cache holds no partial valid line.

## Timing
- Cycle 0: miss detected in IDLE, `stall`=1.
- Cycle 1: first `mem_req`/`mem_addr`.
- Each beat needs ≥1 cycle; `mem_req` and `mem_addr` are stable until `mem_ack`.
- Next beat's address appears in the cycle after an ack. `mem_req` stays high between beats, so back-to-back acks are legal.
- `fill_done` comes in the cycle after the last ack. IDLE follows one cycle later, where the lookup re-evaluates and hits.
- Minimum miss penalty with ack every cycle: `stall` is high for LINE_WORDS+2 cycles (6 for the default).
- A new miss may be detected in the first IDLE cycle after DONE; there is no dead cycle.

## Test plan
- Hit path: `fetch_req`=1, `hit`=1, `pc`=0x00000000..0x00000020 stepping by 4 → `stall`=0, `mem_req` never asserts, `miss_count`=0.
- Critical-word miss: LINE_WORDS=4, `pc`=0x00000008, `hit`=0, ack every cycle.
  - `mem_addr` sequence 0x08, 0x0C, 0x00, 0x04.
  - `fill_we` on 4 consecutive cycles; `fill_done` in cycle 5.
  - `stall` high for cycles 0–5; `line_base`=0x00000000; `miss_count`=1.
- Wait states: `pc`=0x00000014, each ack delayed 3 cycles → `mem_req` and `mem_addr` hold until each ack. Order is 0x14, 0x18, 0x1C, 0x10. A spurious `mem_ack` while `mem_req`=0 causes no write.
- Reset mid-refill: assert `reset` after 2 of 4 acks → next edge gives `mem_req`=0, state IDLE, `miss_count`=0, and no `fill_done` ever pulses.
- Back-to-back misses on `pc`=0x00000000 then 0x00000010 → second refill starts the cycle after IDLE re-entry, and `line_base` updates to 0x00000010.
- Saturation: COUNT_W=2, 5 misses → `miss_count` sequence 1, 2, 3, 3, 3.
